// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock monitor.
//   clk_mon_state_t : monitor FSM state encoding
//   CLK_MON_*       : default expected period / loss timeout (100 MHz ref, 25 MHz monitored)
//   sat_inc8        : saturating 8-bit increment used by the error counter
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } clk_mon_state_t;

    localparam int CLK_MON_EXPECTED_25MHZ  = 4;
    localparam int CLK_MON_TIMEOUT_DEFAULT = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input and detects its rising edges.
//   clk_i    : sampling clock
//   rst_i    : synchronous active-high reset
//   async_i  : asynchronous level input
//   edge_o   : combinational rising-edge indication (synchronized level & ~prev)
//   strobe_o : registered one-cycle pulse per rising edge
module sync_edge_detect
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o,
    output logic strobe_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   strobe_q;

    assign edge_o   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign strobe_o = strobe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q   <= sync_q[SYNC_STAGES-1];
            strobe_q <= edge_o;
        end
    end

endmodule

// File: rtl/clk_monitor.sv
// Measures the period of clk_mon in clk_ref cycles and tracks lock / loss.
//   clk_ref      : reference clock, all logic runs on it
//   rst          : synchronous active-high reset
//   clk_mon      : monitored clock, sampled as asynchronous data
//   edge_strobe  : one-cycle pulse per detected rising edge of clk_mon
//   period       : last measured period (saturating)
//   period_valid : pulses with edge_strobe whenever period holds a real measurement
//   locked       : high while in LOCKED
//   clk_lost     : high while in LOST
//   err_count    : saturating count of lock losses
//
// state   | meaning
// IDLE    | no edge seen since reset
// ACQUIRE | counting consecutive in-tolerance periods
// LOCKED  | LOCK_COUNT good periods seen, monitoring for deviation
// LOST    | no edge for TIMEOUT cycles
module clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXPECTED_PERIOD = CLK_MON_EXPECTED_25MHZ,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = CLK_MON_TIMEOUT_DEFAULT,
    parameter int PERIOD_W        = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk_ref,
    input  logic                rst,
    input  logic                clk_mon,
    output logic                edge_strobe,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                clk_lost,
    output logic [7:0]          err_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [PERIOD_W-1:0] EXP_W   = PERIOD_W'(EXPECTED_PERIOD);
    localparam logic [PERIOD_W-1:0] TOL_W   = PERIOD_W'(TOLERANCE);
    localparam logic [PERIOD_W-1:0] TMO_W   = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [GOOD_W-1:0]   LOCK_W  = GOOD_W'(LOCK_COUNT);

    logic edge_det;

    clk_mon_state_t      state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pv_q, pv_d;
    logic                have_q, have_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [7:0]          err_q, err_d;
    logic                locked_q, lost_q;

    logic [PERIOD_W-1:0] dev;
    logic                in_tol;
    logic                timeout;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk_ref),
        .rst_i    (rst),
        .async_i  (clk_mon),
        .edge_o   (edge_det),
        .strobe_o (edge_strobe)
    );

    // Full-width unsigned deviation; cnt saturates so this never wraps.
    assign dev     = (cnt_q >= EXP_W) ? (cnt_q - EXP_W) : (EXP_W - cnt_q);
    assign in_tol  = (dev <= TOL_W);
    // An edge on the timeout cycle takes priority and is judged as a period.
    assign timeout = ~edge_det & (cnt_q == TMO_W);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_d    = err_q;
        have_d   = have_q | edge_det;
        pv_d     = edge_det & have_q;
        period_d = edge_det ? cnt_q : period_q;
        if (edge_det)
            cnt_d = PERIOD_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + PERIOD_W'(1);

        unique case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (edge_det) begin
                    if (in_tol) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == LOCK_W)
                            state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (edge_det && !in_tol) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                    err_d   = sat_inc8(err_q);
                end
            end
            LOST: begin
                if (edge_det) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = LOST;
            if (state_q == LOCKED)
                err_d = sat_inc8(err_q);
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            have_q   <= 1'b0;
            good_q   <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            have_q   <= have_d;
            good_q   <= good_d;
            err_q    <= err_d;
            locked_q <= (state_q == LOCKED);
            lost_q   <= (state_q == LOST);
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign clk_lost     = lost_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_clk_monitor.sv
module tb_clk_monitor;

    localparam int S_IDLE = 0, S_ACQ = 1, S_LOCKED = 2, S_LOST = 3;
    localparam int EXP_P = 4, LOCKN = 4, TMO = 16;

    logic clk_ref = 1'b0;
    logic rst     = 1'b1;
    logic clk_mon = 1'b0;

    logic       es  [2];
    logic [7:0] per [2];
    logic       pv  [2];
    logic       lk  [2];
    logic       lo  [2];
    logic [7:0] err [2];
    logic [19:0] act [2];

    always #5 clk_ref = ~clk_ref;

    clk_monitor #(.TOLERANCE(0)) u_dut0 (
        .clk_ref(clk_ref), .rst(rst), .clk_mon(clk_mon),
        .edge_strobe(es[0]), .period(per[0]), .period_valid(pv[0]),
        .locked(lk[0]), .clk_lost(lo[0]), .err_count(err[0])
    );

    clk_monitor #(.TOLERANCE(1)) u_dut1 (
        .clk_ref(clk_ref), .rst(rst), .clk_mon(clk_mon),
        .edge_strobe(es[1]), .period(per[1]), .period_valid(pv[1]),
        .locked(lk[1]), .clk_lost(lo[1]), .err_count(err[1])
    );

    assign act[0] = {es[0], pv[0], lk[0], lo[0], per[0], err[0]};
    assign act[1] = {es[1], pv[1], lk[1], lo[1], per[1], err[1]};

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    // Reference model: edge timing, periods and lock state from the rules.
    bit hist [3];
    int m_age  [2];
    int m_st   [2];
    int m_good [2];
    int m_err  [2];
    bit m_have [2];
    bit m_es [2], m_pv [2], m_lk [2], m_lo [2];
    int m_per [2];
    int tol [2] = '{0, 1};

    bit wave [$];

    function automatic logic [19:0] exp_vec(input int i);
        logic [7:0] p8, e8;
        p8 = 8'(m_per[i]);
        e8 = 8'(m_err[i]);
        return {m_es[i], m_pv[i], m_lk[i], m_lo[i], p8, e8};
    endfunction

    task automatic push_period(input int p);
        for (int k = 0; k < p; k++) wave.push_back(k < (p + 1) / 2);
    endtask

    task automatic tick(input bit mon, input bit r);
        bit e;
        int meas, dev;
        bit intol;
        clk_mon = mon;
        rst     = r;
        @(posedge clk_ref);
        // Rising edge seen by the monitor: sample taken SYNC_STAGES edges ago high,
        // the one before it low.
        e = hist[1] & ~hist[2];
        if (r) begin
            hist = '{0, 0, 0};
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = mon;
        end
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_age[i] = 0; m_st[i] = S_IDLE; m_good[i] = 0; m_err[i] = 0; m_have[i] = 0;
                m_es[i] = 0; m_pv[i] = 0; m_lk[i] = 0; m_lo[i] = 0; m_per[i] = 0;
            end else begin
                meas = (m_age[i] > 255) ? 255 : m_age[i];
                dev  = (meas >= EXP_P) ? meas - EXP_P : EXP_P - meas;
                intol = (dev <= tol[i]);
                m_lk[i] = (m_st[i] == S_LOCKED);
                m_lo[i] = (m_st[i] == S_LOST);
                m_es[i] = e;
                m_pv[i] = e && m_have[i];
                if (e) begin
                    m_per[i]  = meas;
                    m_have[i] = 1;
                    if (m_st[i] == S_ACQ && intol) begin
                        m_good[i]++;
                        if (m_good[i] == LOCKN) m_st[i] = S_LOCKED;
                    end else if (m_st[i] == S_LOCKED && !intol) begin
                        m_st[i] = S_ACQ; m_good[i] = 0;
                        if (m_err[i] < 255) m_err[i]++;
                    end else if (m_st[i] != S_LOCKED) begin
                        m_st[i] = S_ACQ; m_good[i] = 0;
                    end
                    m_age[i] = 1;
                end else begin
                    if (meas == TMO) begin
                        if (m_st[i] == S_LOCKED && m_err[i] < 255) m_err[i]++;
                        m_st[i] = S_LOST;
                    end
                    if (m_age[i] < 100000) m_age[i]++;
                end
            end
        end
        cyc++;
        @(negedge clk_ref);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            asserts++;
            if (act[i] !== 20'h0) begin
                fails++;
                $display("FAIL reset_zero dut%0d actual %h required %h", i, act[i], 20'h0);
            end
            asserts++;
            if (act[i] !== exp_vec(i)) begin
                fails++;
                $display("FAIL reset_model dut%0d actual %h required %h", i, act[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_lock();
        int n_es = 0, cyc5 = -1, lk_cyc = -1;
        for (int k = 0; k < 8; k++) push_period(4);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL lock_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
            if (es[0]) begin
                n_es++;
                if (n_es == 5) cyc5 = cyc;
            end
            if (lk[0] && lk_cyc < 0) lk_cyc = cyc;
        end
        asserts++;
        if (lk_cyc != cyc5 + 1 || cyc5 < 0) begin
            fails++;
            $display("FAIL lock_latency actual locked at %0d required %0d", lk_cyc, cyc5 + 1);
        end
        asserts++;
        if (lk[0] !== 1'b1 || err[0] !== 8'd0 || per[0] !== 8'd4) begin
            fails++;
            $display("FAIL lock_status actual lk=%b err=%0d per=%0d required lk=1 err=0 per=4", lk[0], err[0], per[0]);
        end
    endtask

    task automatic test_glitch();
        bit saw_unlock = 0, saw6 = 0;
        push_period(6);
        for (int k = 0; k < 6; k++) push_period(4);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL glitch_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
            if (!lk[0]) saw_unlock = 1;
            if (pv[0] && per[0] == 8'd6) saw6 = 1;
        end
        asserts++;
        if (!saw_unlock || !saw6 || lk[0] !== 1'b1 || err[0] !== 8'd1) begin
            fails++;
            $display("FAIL glitch_status actual unlock=%b p6=%b lk=%b err=%0d required 1 1 1 1",
                     saw_unlock, saw6, lk[0], err[0]);
        end
    endtask

    task automatic test_loss();
        for (int k = 0; k < 40; k++) wave.push_back(1'b0);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL loss_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
        end
        asserts++;
        if (lo[0] !== 1'b1 || lk[0] !== 1'b0 || err[0] !== 8'd2) begin
            fails++;
            $display("FAIL loss_status actual lost=%b lk=%b err=%0d required lost=1 lk=0 err=2", lo[0], lk[0], err[0]);
        end
    endtask

    task automatic test_boundary();
        bit cleared = 0, relost = 0, saw16 = 0;
        push_period(16);
        for (int k = 0; k < 6; k++) push_period(4);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL boundary_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
            if (!lo[0]) cleared = 1;
            else if (cleared) relost = 1;
            if (pv[0] && per[0] == 8'd16) saw16 = 1;
        end
        asserts++;
        if (!saw16 || relost || lk[0] !== 1'b1 || err[0] !== 8'd2) begin
            fails++;
            $display("FAIL boundary_status actual p16=%b relost=%b lk=%b err=%0d required 1 0 1 2",
                     saw16, relost, lk[0], err[0]);
        end
    endtask

    task automatic test_reset_mid_lock();
        bit first = 1, first_pv = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            asserts++;
            if (act[i] !== 20'h0) begin
                fails++;
                $display("FAIL midreset_zero dut%0d actual %h required %h", i, act[i], 20'h0);
            end
        end
        for (int k = 0; k < 7; k++) push_period(4);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL midreset_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
            if (es[0] && first) begin
                first = 0;
                first_pv = pv[0];
            end
        end
        asserts++;
        if (first || first_pv || lk[0] !== 1'b1 || err[0] !== 8'd0) begin
            fails++;
            $display("FAIL midreset_status actual noedge=%b pv1=%b lk=%b err=%0d required 0 0 1 0",
                     first, first_pv, lk[0], err[0]);
        end
    endtask

    task automatic test_tolerance();
        tick(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            push_period(3);
            push_period(5);
        end
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL tol_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
        end
        asserts++;
        if (lk[1] !== 1'b1 || lk[0] !== 1'b0) begin
            fails++;
            $display("FAIL tol_lock actual lk1=%b lk0=%b required lk1=1 lk0=0", lk[1], lk[0]);
        end
        push_period(6);
        push_period(4);
        push_period(4);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL tol_unlock_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
        end
        asserts++;
        if (lk[1] !== 1'b0 || err[1] !== 8'd1 || err[0] !== 8'd0) begin
            fails++;
            $display("FAIL tol_unlock actual lk1=%b err1=%0d err0=%0d required 0 1 0", lk[1], err[1], err[0]);
        end
    endtask

    task automatic test_err_saturation();
        for (int n = 0; n < 262; n++) begin
            for (int k = 0; k < 4; k++) push_period(4);
            push_period(int'($urandom_range(6, 12)));
            while (wave.size() > 0) begin
                tick(wave.pop_front(), 1'b0);
                for (int i = 0; i < 2; i++) begin
                    asserts++;
                    if (act[i] !== exp_vec(i)) begin
                        fails++;
                        $display("FAIL sat_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            asserts++;
            if (err[i] !== 8'd255) begin
                fails++;
                $display("FAIL err_saturate dut%0d actual %0d required 255", i, err[i]);
            end
        end
    endtask

    task automatic test_random();
        bit saw255 = 0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) push_period(int'($urandom_range(14, 40)));
            else push_period(int'($urandom_range(2, 8)));
        end
        push_period(300);
        push_period(4);
        push_period(4);
        while (wave.size() > 0) begin
            tick(wave.pop_front(), 1'b0);
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (act[i] !== exp_vec(i)) begin
                    fails++;
                    $display("FAIL random_model dut%0d cyc %0d actual %h required %h", i, cyc, act[i], exp_vec(i));
                end
            end
            if (pv[0] && per[0] == 8'd255) saw255 = 1;
        end
        asserts++;
        if (!saw255) begin
            fails++;
            $display("FAIL period_saturate actual seen=%b required 1", saw255);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_loss();
        test_boundary();
        test_reset_mid_lock();
        test_tolerance();
        test_err_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
